// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared state/priority types and the reset priority order
package dma_arb_pkg;
  localparam int MAX_CH = 8;
  localparam int MAX_W = 3;
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} arb_state_e;
  typedef enum logic {FIXED = 1'b0, ROTATING = 1'b1} priority_e;
  function automatic logic [MAX_CH-1:0][MAX_W-1:0] RESET_ORDER();
    logic [MAX_CH-1:0][MAX_W-1:0] o;
    for (int k = 0; k < MAX_CH; k++) o[k] = MAX_W'(k);
    return o;
  endfunction
endpackage

// File: rtl/dma_prio_select.sv
// dma_prio_select: first requesting channel in an order list wins
module dma_prio_select #(
  parameter int NUM_CH = 4,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH-1:0][CH_W-1:0] order,
  output logic [CH_W-1:0]             winner,
  output logic                        any_req
);
  always_comb begin
    winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[order[k]]) winner = order[k];
  end
  assign any_req = |req;
endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: masked fixed/rotating DMA arbiter with HRQ/HLDA handshake and locked DACK
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] mask,
  input  logic              priority_type,
  input  logic              dreq_sense_low,
  input  logic              dack_sense_high,
  input  logic              HLDA,
  input  logic              xfer_done,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   active_ch,
  output logic              active_valid
);
  localparam logic [MAX_CH-1:0][MAX_W-1:0] RST_ORD = RESET_ORDER();
  arb_state_e state_q, state_d;
  logic hrq_q, hrq_d, valid_q, valid_d, any_req, exit_grant;
  logic [CH_W-1:0] ch_q, ch_d, winner;
  logic [NUM_CH-1:0] req, onehot;
  logic [NUM_CH-1:0][CH_W-1:0] rst_order, rot_order, sel_order, order_q, order_d;
  always_comb begin
    rst_order = '0;
    rot_order = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rst_order[k] = RST_ORD[k][CH_W-1:0];
      rot_order[k] = CH_W'((32'(ch_q) + 32'(k) + 32'd1) % 32'(NUM_CH));
    end
  end
  assign req = (DREQ ^ {NUM_CH{dreq_sense_low}}) & ~mask;
  assign sel_order = (priority_type == ROTATING) ? order_q : rst_order;
  assign exit_grant = (state_q == GRANT) && (!HLDA || xfer_done || !req[ch_q]);
  dma_prio_select #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_sel (
    .req(req),
    .order(sel_order),
    .winner(winner),
    .any_req(any_req)
  );
  always_comb begin
    state_d = state_q;
    hrq_d = hrq_q;
    valid_d = valid_q;
    ch_d = ch_q;
    order_d = exit_grant ? rot_order : order_q;
    case (state_q)
      IDLE: begin
        state_d = any_req ? REQ : IDLE;
        hrq_d = any_req;
      end
      REQ: begin
        state_d = (HLDA && any_req) ? GRANT : (any_req ? REQ : RELEASE);
        hrq_d = any_req;
        valid_d = HLDA && any_req;
        ch_d = (HLDA && any_req) ? winner : ch_q;
      end
      GRANT: begin
        state_d = exit_grant ? RELEASE : GRANT;
        hrq_d = !exit_grant;
        valid_d = !exit_grant;
      end
      RELEASE: begin
        state_d = IDLE;
        hrq_d = any_req;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      hrq_q <= 1'b0;
      valid_q <= 1'b0;
      ch_q <= '0;
      order_q <= rst_order;
    end else begin
      state_q <= state_d;
      hrq_q <= hrq_d;
      valid_q <= valid_d;
      ch_q <= ch_d;
      order_q <= order_d;
    end
  end
  assign onehot = valid_q ? (NUM_CH'(1) << ch_q) : '0;
  assign DACK = onehot ^ {NUM_CH{~dack_sense_high}};
  assign HRQ = hrq_q;
  assign active_ch = ch_q;
  assign active_valid = valid_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed self-checking bench for the DMA channel arbiter
module tb_dma_channel_arbiter;
  logic CLK = 1'b0;
  logic RESET, priority_type, dreq_sense_low, dack_sense_high, HLDA, xfer_done;
  logic [3:0] DREQ, mask, DACK;
  logic HRQ, active_valid;
  logic [1:0] active_ch;
  int tests = 0;
  int failed = 0;
  int rot_exp[5] = '{0, 1, 2, 3, 0};
  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .mask(mask),
    .priority_type(priority_type),
    .dreq_sense_low(dreq_sense_low),
    .dack_sense_high(dack_sense_high),
    .HLDA(HLDA),
    .xfer_done(xfer_done),
    .HRQ(HRQ),
    .DACK(DACK),
    .active_ch(active_ch),
    .active_valid(active_valid)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    RESET = 1'b0;
    DREQ = 4'b0000;
    mask = 4'b0000;
    HLDA = 1'b0;
    xfer_done = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask
  initial begin
    priority_type = 1'b0;
    dreq_sense_low = 1'b0;
    dack_sense_high = 1'b1;
    do_reset();
    chk("rst_hrq", 32'(HRQ), 0);
    chk("rst_valid", 32'(active_valid), 0);
    chk("rst_ch", 32'(active_ch), 0);
    chk("rst_dack", 32'(DACK), 0);
    DREQ = 4'b1010;
    tick();
    chk("fix_hrq", 32'(HRQ), 1);
    chk("fix_dack_wait", 32'(DACK), 0);
    tick();
    HLDA = 1'b1;
    tick();
    chk("fix_dack", 32'(DACK), 32'b0010);
    chk("fix_ch", 32'(active_ch), 1);
    chk("fix_valid", 32'(active_valid), 1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("fix_rel_dack", 32'(DACK), 0);
    chk("fix_rel_hrq", 32'(HRQ), 0);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    chk("fix_idle_hrq", 32'(HRQ), 0);
    do_reset();
    priority_type = 1'b1;
    DREQ = 4'b1111;
    HLDA = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rot_ch%0d", i), 32'(active_ch), 32'(rot_exp[i]));
      chk($sformatf("rot_valid%0d", i), 32'(active_valid), 1);
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk($sformatf("rot_gap%0d", i), 32'(HRQ), 0);
      tick();
      chk($sformatf("rot_rehrq%0d", i), 32'(HRQ), 1);
      tick();
      tick();
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    tick();
    do_reset();
    priority_type = 1'b0;
    DREQ = 4'b0100;
    HLDA = 1'b1;
    tick();
    tick();
    chk("lock_dack", 32'(DACK), 32'b0100);
    DREQ = 4'b0101;
    tick();
    tick();
    chk("lock_hold_dack", 32'(DACK), 32'b0100);
    chk("lock_hold_ch", 32'(active_ch), 2);
    xfer_done = 1'b1;
    DREQ = 4'b0001;
    tick();
    xfer_done = 1'b0;
    chk("lock_rel_dack", 32'(DACK), 0);
    tick();
    tick();
    tick();
    chk("lock_next_dack", 32'(DACK), 32'b0001);
    chk("lock_next_ch", 32'(active_ch), 0);
    DREQ = 4'b0000;
    tick();
    chk("drop_exit_valid", 32'(active_valid), 0);
    HLDA = 1'b0;
    tick();
    do_reset();
    mask = 4'b0001;
    DREQ = 4'b0001;
    tick();
    tick();
    tick();
    chk("mask_hrq_low", 32'(HRQ), 0);
    mask = 4'b0000;
    tick();
    chk("unmask_hrq", 32'(HRQ), 1);
    DREQ = 4'b0000;
    tick();
    chk("req_drop_hrq", 32'(HRQ), 0);
    tick();
    dreq_sense_low = 1'b1;
    dack_sense_high = 1'b0;
    do_reset();
    DREQ = 4'b1101;
    chk("pol_idle_dack", 32'(DACK), 32'b1111);
    HLDA = 1'b1;
    tick();
    tick();
    chk("pol_dack", 32'(DACK), 32'b1101);
    chk("pol_ch", 32'(active_ch), 1);
    DREQ = 4'b1111;
    tick();
    chk("pol_rel_dack", 32'(DACK), 32'b1111);
    HLDA = 1'b0;
    tick();
    dreq_sense_low = 1'b0;
    dack_sense_high = 1'b1;
    do_reset();
    priority_type = 1'b1;
    DREQ = 4'b0001;
    HLDA = 1'b1;
    tick();
    tick();
    xfer_done = 1'b1;
    DREQ = 4'b1000;
    tick();
    xfer_done = 1'b0;
    tick();
    tick();
    tick();
    chk("rr_grant_ch3", 32'(active_ch), 3);
    chk("rr_dack3", 32'(DACK), 32'b1000);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    chk("midrst_hrq", 32'(HRQ), 0);
    chk("midrst_dack", 32'(DACK), 0);
    chk("midrst_valid", 32'(active_valid), 0);
    DREQ = 4'b1001;
    tick();
    tick();
    chk("midrst_order_ch", 32'(active_ch), 0);
    chk("midrst_order_dack", 32'(DACK), 32'b0001);
    HLDA = 1'b0;
    tick();
    chk("hlda_abort_valid", 32'(active_valid), 0);
    chk("hlda_abort_hrq", 32'(HRQ), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
